// File: rtl/phase_sequencer.sv
// Run/stop controller and phase generator for the multicycle core.
// Steps the datapath through NUM_PHASES one-hot phases with run, single-step, halt and stall control.
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step,
  input  logic                  halt,
  input  logic                  stall,
  output logic [2:0]            phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [2:0] LAST = 3'(NUM_PHASES - 1);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  state_t           state, state_nx;
  logic [2:0]       phase_nx;
  logic [CNT_W-1:0] count_nx;
  logic             stop_req, stop_nx;
  logic             halt_req, halt_nx;
  logic             exec_q, step_q;
  logic             exec_pulse, step_pulse;

  assign exec_pulse = exec & ~exec_q;
  assign step_pulse = step & ~step_q;
  assign running    = (state == RUN) || (state == STEP);
  assign halted     = (state == HALTED);

  // Edge-detect registers reset high so a button held through reset release does not fire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      phase       <= 3'd0;
      instr_count <= '0;
      stop_req    <= 1'b0;
      halt_req    <= 1'b0;
      exec_q      <= 1'b1;
      step_q      <= 1'b1;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      instr_count <= count_nx;
      stop_req    <= stop_nx;
      halt_req    <= halt_nx;
      exec_q      <= exec;
      step_q      <= step;
    end
  end

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    count_nx   = instr_count;
    stop_nx    = stop_req;
    halt_nx    = halt_req;
    phase_en   = '0;
    instr_done = 1'b0;
    case (state)
      IDLE: begin
        phase_nx = 3'd0;
        if (exec_pulse)      state_nx = RUN;
        else if (step_pulse) state_nx = STEP;
      end
      RUN, STEP: begin
        // A stalled cycle freezes everything, including pending requests.
        if (!stall) begin
          phase_en = NUM_PHASES'(1) << phase;
          halt_nx  = halt_req | halt;
          if (state == RUN && exec_pulse) stop_nx = 1'b1;
          if (phase == LAST) begin
            instr_done = 1'b1;
            count_nx   = instr_count + CNT_W'(1);
            phase_nx   = 3'd0;
            if (halt_nx)                             state_nx = HALTED;
            else if (state == STEP || stop_nx)       state_nx = IDLE;
            if (state_nx != state) begin
              stop_nx = 1'b0;
              halt_nx = 1'b0;
            end
          end else begin
            phase_nx = phase + 3'd1;
          end
        end
      end
      HALTED: begin
        phase_nx = 3'd0;
      end
      default: begin
        state_nx = IDLE;
        phase_nx = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed testbench for phase_sequencer (5 phases, 4-bit retired counter so wrap is reachable).
module tb_phase_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       exec  = 1'b0;
  logic       step  = 1'b0;
  logic       halt  = 1'b0;
  logic       stall = 1'b0;
  logic [2:0] phase;
  logic [4:0] phase_en;
  logic       running;
  logic       halted;
  logic       instr_done;
  logic [3:0] instr_count;

  int errors = 0;
  int checks = 0;

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt), .stall(stall),
    .phase(phase), .phase_en(phase_en), .running(running), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || phase_en !== 5'd0 || running !== 1'b0 || halted !== 1'b0 ||
        instr_done !== 1'b0 || instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got ph=%0d en=%b run=%b hlt=%b done=%b cnt=%0d exp all zero",
               phase, phase_en, running, halted, instr_done, instr_count);
    end
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_run;
    logic [4:0] exp_en;
    exec = 1'b1;
    tick;
    exec = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp_en = 5'd1 << (i % 5);
      checks++;
      if (phase !== 3'(i % 5) || phase_en !== exp_en || instr_done !== (i % 5 == 4) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL run_seq cycle %0d got ph=%0d en=%b done=%b run=%b exp ph=%0d en=%b done=%b run=1",
                 i, phase, phase_en, instr_done, running, i % 5, exp_en, (i % 5 == 4));
      end
      tick;
    end
    checks++;
    if (instr_count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL run_count got %0d exp 3", instr_count);
    end
    // stop during phase 0 of the fourth instruction: it must still finish
    exec = 1'b1;
    tick;
    exec = 1'b0;
    repeat (4) tick;
    checks++;
    if (running !== 1'b0 || phase_en !== 5'd0 || instr_count !== 4'd4) begin
      errors++;
      $display("[TB] FAIL run_stop got run=%b en=%b cnt=%0d exp run=0 en=00000 cnt=4", running, phase_en, instr_count);
    end
  endtask

  task automatic test_step;
    step = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (phase !== 3'(i) || phase_en !== (5'd1 << i) || running !== 1'b1) begin
        errors++;
        $display("[TB] FAIL step_seq cycle %0d got ph=%0d en=%b run=%b exp ph=%0d run=1", i, phase, phase_en, running, i);
      end
      tick;
    end
    repeat (14) begin
      checks++;
      if (running !== 1'b0 || phase_en !== 5'd0 || instr_count !== 4'd5) begin
        errors++;
        $display("[TB] FAIL step_idle got run=%b en=%b cnt=%0d exp run=0 en=00000 cnt=5", running, phase_en, instr_count);
      end
      tick;
    end
    step = 1'b0;
    tick;
  endtask

  task automatic test_stop_mid;
    exec = 1'b1;
    tick;
    exec = 1'b0;
    tick;
    tick;
    checks++;
    if (phase !== 3'd2) begin
      errors++;
      $display("[TB] FAIL stop_mid_ph2 got %0d exp 2", phase);
    end
    exec = 1'b1;
    tick;
    exec = 1'b0;
    checks++;
    if (phase !== 3'd3 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_mid_ph3 got ph=%0d run=%b exp ph=3 run=1", phase, running);
    end
    tick;
    checks++;
    if (phase !== 3'd4 || instr_done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_mid_commit got ph=%0d done=%b exp ph=4 done=1", phase, instr_done);
    end
    tick;
    checks++;
    if (running !== 1'b0 || instr_count !== 4'd6) begin
      errors++;
      $display("[TB] FAIL stop_mid_idle got run=%b cnt=%0d exp run=0 cnt=6", running, instr_count);
    end
    exec = 1'b1;
    tick;
    exec = 1'b0;
    checks++;
    if (running !== 1'b1 || phase !== 3'd0 || phase_en !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL resume got run=%b ph=%0d en=%b exp run=1 ph=0 en=00001", running, phase, phase_en);
    end
  endtask

  task automatic test_stall;
    int dones;
    dones = 0;
    repeat (3) begin
      if (instr_done === 1'b1) dones++;
      tick;
    end
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (phase !== 3'd3 || phase_en !== 5'd0 || instr_done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d got ph=%0d en=%b done=%b exp ph=3 en=00000 done=0", i, phase, phase_en, instr_done);
      end
      tick;
    end
    stall = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd3 || phase_en !== 5'b01000) begin
      errors++;
      $display("[TB] FAIL stall_release got ph=%0d en=%b exp ph=3 en=01000", phase, phase_en);
    end
    tick;
    if (instr_done === 1'b1) dones++;
    tick;
    checks++;
    if (dones !== 1 || instr_count !== 4'd7 || phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL stall_commit got dones=%0d cnt=%0d ph=%0d exp dones=1 cnt=7 ph=0", dones, instr_count, phase);
    end
  endtask

  task automatic test_halt;
    tick;
    halt = 1'b1;
    tick;
    halt = 1'b0;
    repeat (3) tick;
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || phase !== 3'd0 || phase_en !== 5'd0 || instr_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL halt_enter got hlt=%b run=%b ph=%0d en=%b cnt=%0d exp hlt=1 run=0 ph=0 en=00000 cnt=8",
               halted, running, phase, phase_en, instr_count);
    end
    exec = 1'b1; tick; exec = 1'b0; tick;
    step = 1'b1; tick; step = 1'b0; tick;
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || instr_count !== 4'd8) begin
      errors++;
      $display("[TB] FAIL halt_sticky got hlt=%b run=%b cnt=%0d exp hlt=1 run=0 cnt=8", halted, running, instr_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || running !== 1'b0 || instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL halt_reset got hlt=%b run=%b cnt=%0d exp hlt=0 run=0 cnt=0", halted, running, instr_count);
    end
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_wrap;
    exec = 1'b1;
    tick;
    exec = 1'b0;
    repeat (75) tick;
    checks++;
    if (instr_count !== 4'd15 || phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL wrap_preload got cnt=%0d ph=%0d exp cnt=15 ph=0", instr_count, phase);
    end
    repeat (4) tick;
    checks++;
    if (instr_done !== 1'b1 || instr_count !== 4'd15) begin
      errors++;
      $display("[TB] FAIL wrap_commit got done=%b cnt=%0d exp done=1 cnt=15", instr_done, instr_count);
    end
    tick;
    checks++;
    if (instr_count !== 4'd0 || running !== 1'b1 || phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL wrap_zero got cnt=%0d run=%b ph=%0d exp cnt=0 run=1 ph=0", instr_count, running, phase);
    end
    tick;
    tick;
    exec = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (phase !== 3'd0 || running !== 1'b0 || phase_en !== 5'd0 || instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL midreset got ph=%0d run=%b en=%b cnt=%0d exp all zero", phase, running, phase_en, instr_count);
    end
    tick;
    reset = 1'b1;
    repeat (3) tick;
    checks++;
    if (running !== 1'b0 || phase_en !== 5'd0 || instr_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL held_exec got run=%b en=%b cnt=%0d exp run=0 en=00000 cnt=0", running, phase_en, instr_count);
    end
    exec = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_run;
    test_step;
    test_stop_mid;
    test_stall;
    test_halt;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Run/stop controller and phase generator for the multicycle processor core. Produces the phase counter and one-hot phase enables that step the datapath through fetch/decode/execute/memory/writeback. Supports free-run, single-instruction step, architectural halt and memory stall. Sits between the board buttons (exec, step), the decoder (halt) and the memory interface (stall), and replaces the free-running phase counter feeding the control unit.

Parameters:
NUM_PHASES, 5, phases per instruction; legal 2..8; last phase index NUM_PHASES-1.
CNT_W, 16, width of retired-instruction counter.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 forces reset state immediately
exec  input  1  run/stop button, synchronous level; rising edge acts
step  input  1  single-step button, synchronous level; rising edge acts
halt  input  1  halt request from decoder, level, sampled every active cycle
stall  input  1  memory busy; freezes phase while high
phase  output  3  current phase index 0..NUM_PHASES-1
phase_en  output  NUM_PHASES  one-hot enable of current phase to datapath
running  output  1  1 in RUN or STEP state
halted  output  1  1 in HALTED state
instr_done  output  1  1 in cycle final phase commits
instr_count  output  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- Reset (reset=0): state=IDLE, phase=0, phase_en=0, running=0, halted=0, instr_done=0, instr_count=0, stop_req=0, halt_req=0; edge-detect registers exec_q=1, step_q=1 (button held across reset release does not fire).
- Edge detect: exec_pulse = exec & ~exec_q; step_pulse = step & ~step_q; exec_q/step_q update every cycle in all states.
- States: IDLE, RUN, STEP, HALTED (2-bit encoding, implementer's choice).
- IDLE: phase held 0, phase_en=0. exec_pulse -> RUN; else step_pulse -> STEP. Simultaneous: exec wins.
- RUN/STEP, active cycle: phase_en = onehot(phase) & ~stall (combinational on stall). stall=1: phase, state, requests held; phase_en=0; instr_done=0.
- Advance: stall=0 and phase<NUM_PHASES-1 -> phase+1 next cycle.
- Commit: stall=0 and phase==NUM_PHASES-1 -> instr_done=1 this cycle; instr_count+1 at edge; phase -> 0.
- Requests: exec_pulse in RUN sets stop_req; exec_pulse in STEP ignored. halt=1 in any active non-stalled cycle sets halt_req (includes commit cycle). step_pulse in RUN/STEP ignored.
- Boundary decision on commit, priority: halt_req -> HALTED; else state==STEP -> IDLE; else stop_req -> IDLE; else stay RUN. Requests clear on leaving RUN/STEP.
- Stop never truncates an instruction: first instruction after start always completes all NUM_PHASES phases.
- HALTED: phase=0, phase_en=0, halted=1; exec/step ignored; exit only via reset.
- Latency: exec_pulse at edge N -> RUN, phase_en[0]=1 in cycle N+1. Uninterrupted instruction = NUM_PHASES cycles; each stall cycle adds one.
- Reset asserted mid-instruction: immediate return to reset state, partial instruction not counted.
- instr_count wraps to 0 from all-ones without side effect.

Test Plan:
- Reset, exec pulse 1 cycle -> phase 0,1,2,3,4,0,... one per cycle; phase_en 00001,00010,...,10000; instr_done every 5th cycle; instr_count=3 after 15 active cycles.
- Step pulse from IDLE -> exactly 5 phases, instr_count 0->1, back to IDLE (running=0, phase_en=0); step held high 20 cycles -> still one instruction.
- RUN, exec pulse during phase 2 -> phases 3,4 complete, instr_count+1, IDLE next; second exec pulse -> resumes at phase 0.
- RUN, stall high 3 cycles in phase 3 -> phase stays 3, phase_en=0 those cycles, instruction takes 8 cycles, instr_done once.
- halt high one cycle in phase 1 -> instruction completes, halted=1, later exec/step pulses ignored; reset low -> IDLE, count 0.
- Preload by running 2^CNT_W-1 instructions (CNT_W=4 build) -> next commit wraps instr_count to 0; reset low during phase 2 with exec held -> IDLE, no restart after release.
